spi_cfg_controller: RTL and testbench

Host-side SPI controller that sequences 16-bit write frames into the chip's SPI configuration peripheral (output-enable, PWM-enable and PWM duty-cycle registers). It accepts address/data commands through a valid/ready port, buffers them in a small FIFO, and serialises each one as a mode-0, MSB-first frame on `sclk`, `ncs` and `copi`. Between frames it enforces an `ncs`-high gap so the peripheral can commit each frame on its `ncs` rising edge.

---
 rtl/spi_cfg_pkg.sv | 34 +++
 rtl/spi_cfg_cmd_fifo.sv | 82 ++++++++
 rtl/spi_cfg_controller.sv | 184 ++++++++++++++++++
 tb/tb_spi_cfg_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration host controller.
// Holds the FSM state encoding, frame geometry, the queued command payload
// and the peripheral register map.
package spi_cfg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_BITS  = 7;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned CMD_BITS   = ADDR_BITS + DATA_BITS;
    localparam logic        WRITE_FLAG = 1'b1;

    // Peripheral register map
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY  = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_e;

    // Queued write command; bit order matches the frame body after the write flag
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } cmd_t;

endpackage

// File: rtl/spi_cfg_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and a registered
// head entry, so the consumer sees the oldest entry without a read latency.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push/wr_data write an entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   full, empty  occupancy flags
//   head         oldest entry, valid while !empty
module spi_cfg_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = head_q;

    // Pointer, flag and head update
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == PW'(DEPTH));
        empty_d  = (count_d == '0);
        // The incoming entry becomes the head when nothing older remains
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_data;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    // Storage array needs no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_cfg_controller.sv
// Host-side SPI controller: queues address/data write commands and sends each
// as a 16-bit mode-0 MSB-first frame {1, addr, data}, leaving ncs high for a
// guaranteed gap between frames so the peripheral can commit on ncs rising.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_addr (7b), cmd_data (8b)
//   sclk, ncs, copi        SPI bus (sclk idles low, ncs idles high)
//   busy                   commands pending or a frame/gap in progress
//   frame_done             one-cycle pulse coincident with ncs rising
module spi_cfg_controller
    import spi_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = 4;
    localparam int unsigned GAP_W = 8;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  ncs_q, ncs_d;
    logic                  copi_q, copi_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    cmd_t                  wr_cmd;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CMD_BITS-1:0]   fifo_head;
    logic                  div_last;
    logic                  active;

    assign wr_cmd     = '{addr: cmd_addr, data: cmd_data};
    assign fifo_push  = cmd_valid && cmd_ready;
    // Full flag is a flop inside the FIFO; no same-cycle pop bypass
    assign cmd_ready  = !fifo_full;

    assign sclk       = sclk_q;
    assign ncs        = ncs_q;
    assign copi       = copi_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    spi_cfg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (wr_cmd),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Next-state, counters and pin values
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        div_last = (div_q == DIV_W'(CLK_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = {WRITE_FLAG, fifo_head};
                    bit_d    = '0;
                    div_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_HIGH;
                end
            end
            ST_HOLD: begin
                div_d = div_q + DIV_W'(1);
                if (div_last) begin
                    div_d   = '0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins follow the current state one cycle later, keeping every
        // interval the same length as the state that produced it
        active       = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                       (state_q == ST_LOW)   || (state_q == ST_HOLD);
        ncs_d        = !active;
        sclk_d       = (state_q == ST_HIGH);
        copi_d       = active && shreg_q[FRAME_BITS-1];
        // Pulse on the same edge that raises ncs after a completed frame
        frame_done_d = (state_q == ST_GAP) && !ncs_q;
        busy_d       = !fifo_empty || (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            ncs_q        <= 1'b1;
            copi_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            ncs_q        <= ncs_d;
            copi_q       <= copi_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Bench for spi_cfg_controller: a bus monitor rebuilds frames from sclk/copi,
// models the peripheral register file, and directed vectors plus hand-written
// sequences compare frames, timing and register contents.
module tb_spi_cfg_controller;
    import spi_cfg_pkg::*;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned GAP_CYCLES = 8;
    localparam int          FRAME_LEN  = 33 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       busy;
    logic       frame_done;

    spi_cfg_controller #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .sclk       (sclk),
        .ncs        (ncs),
        .copi       (copi),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor and peripheral model, sampled on the falling clock edge
    logic        ncs_p = 1'b1;
    logic        sclk_p = 1'b0;
    int          low_len = 0;
    int          high_run = 0;
    int          rises = 0;
    logic [15:0] sr = '0;
    logic [15:0] frames[$];
    int          frame_lens[$];
    int          fd_count = 0;
    int          partial = 0;
    int          min_gap = 1000000;
    bit          seen_frame = 1'b0;
    logic [7:0]  regs[5];

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (!ncs) begin
            if (ncs_p) begin
                if (seen_frame && high_run < min_gap) min_gap = high_run;
                low_len = 0;
                rises   = 0;
            end
            low_len++;
            if (sclk && !sclk_p) begin
                sr = {sr[14:0], copi};
                rises++;
            end
        end else begin
            if (!ncs_p) begin
                if (rises == 16) begin
                    frames.push_back(sr);
                    frame_lens.push_back(low_len);
                    seen_frame = 1'b1;
                    if (sr[15] && sr[14:8] < 7'd5) regs[int'(sr[14:8])] = sr[7:0];
                end else begin
                    partial++;
                end
                high_run = 0;
            end
            high_run++;
        end
        ncs_p  = ncs;
        sclk_p = sclk;
    end

    task automatic push_cmd(input logic [6:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", n);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        #1;
        while ((busy || !ncs) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || !ncs) begin
            checks++;
            errors++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_regs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, fd0, lat, viol, n;
        logic [15:0] exp_frame;

        for (int i = 0; i < 5; i++) begin
            regs[i]     = '0;
            exp_regs[i] = '0;
        end

        vecs[0] = '{ADDR_PWM_DUTY,  8'h80, 16'h8480};
        vecs[1] = '{ADDR_EN_OUT_LO, 8'hA5, 16'h80A5};
        vecs[2] = '{ADDR_EN_OUT_HI, 8'h5A, 16'h815A};
        vecs[3] = '{ADDR_EN_PWM_LO, 8'hFF, 16'h82FF};
        vecs[4] = '{ADDR_EN_PWM_HI, 8'h00, 16'h8300};
        vecs[5] = '{ADDR_PWM_DUTY,  8'h3C, 16'h843C};
        vecs[6] = '{7'h7F,          8'h11, 16'hFF11};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_ncs", 32'(ncs), 32'd1);
        chk("rst_copi", 32'(copi), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single frames: content, latency, length, pulse, register file
        for (int i = 0; i < 7; i++) begin
            n0  = frames.size();
            fd0 = fd_count;
            push_cmd(vecs[i].addr, vecs[i].data);
            lat = 0;
            while (ncs && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("v%0d_start_latency", i), 32'(lat), 32'd2);
            wait_idle(400, $sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_frame_count", i), 32'(frames.size()), 32'(n0 + 1));
            if (frames.size() > n0) begin
                chk($sformatf("v%0d_frame", i), 32'(frames[n0]), 32'(vecs[i].frame));
                chk($sformatf("v%0d_ncs_low_len", i), 32'(frame_lens[n0]), 32'(FRAME_LEN));
            end
            chk($sformatf("v%0d_frame_done_pulses", i), 32'(fd_count - fd0), 32'd1);
            if (vecs[i].addr < 7'd5) exp_regs[int'(vecs[i].addr)] = vecs[i].data;
            for (int r = 0; r < 5; r++) begin
                chk($sformatf("v%0d_reg%0d", i, r), 32'(regs[r]), 32'(exp_regs[r]));
            end
        end

        // Back-pressure: five accepted back to back, sixth refused
        n0      = frames.size();
        fd0     = fd_count;
        min_gap = 1000000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", k), 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b1;
            cmd_addr  = 7'(k);
            cmd_data  = 8'(8'h10 + k);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_ready_sixth", 32'(cmd_ready), 32'd0);
        viol = 0;
        n    = 0;
        while (fd_count == fd0 && n < 400) begin
            @(negedge clk);
            if (cmd_ready) viol++;
            n++;
        end
        chk("bp_ready_low_until_done", 32'(viol), 32'd0);
        wait_idle(2000, "bp_idle");
        chk("bp_frame_count", 32'(frames.size() - n0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            exp_frame = {1'b1, 7'(k), 8'(8'h10 + k)};
            if (frames.size() > n0 + k)
                chk($sformatf("bp_frame_%0d", k), 32'(frames[n0 + k]), 32'(exp_frame));
        end
        chk("bp_min_gap_ok", 32'(min_gap >= int'(GAP_CYCLES) + 1), 32'd1);

        // Push while one entry queued and FSM idle
        n0 = frames.size();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h02;
        cmd_data  = 8'h66;
        @(posedge clk);
        #1;
        chk("pp_count_after_first", 32'(dut.u_fifo.count_q), 32'd1);
        cmd_addr = 7'h03;
        cmd_data = 8'h77;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("pp_count_after_both", 32'(dut.u_fifo.count_q), 32'd1);
        wait_idle(800, "pp_idle");
        chk("pp_frame_count", 32'(frames.size() - n0), 32'd2);
        if (frames.size() > n0 + 1) begin
            chk("pp_frame_a", 32'(frames[n0]), 32'h8266);
            chk("pp_frame_b", 32'(frames[n0 + 1]), 32'h8377);
        end

        // Reset in the middle of a frame with two entries queued
        push_cmd(7'h00, 8'h01);
        push_cmd(7'h01, 8'h02);
        push_cmd(7'h02, 8'h03);
        n0  = frames.size();
        fd0 = fd_count;
        n   = 0;
        while (!(rises == 8 && !ncs) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mr_reached_bit7", 32'(rises == 8 && !ncs), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_ncs", 32'(ncs), 32'd1);
        chk("mr_sclk", 32'(sclk), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        chk("mr_no_frames", 32'(frames.size() - n0), 32'd0);
        chk("mr_no_frame_done", 32'(fd_count - fd0), 32'd0);
        chk("mr_ncs_idle", 32'(ncs), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
